mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the CPU data-memory request interface (the target end of ram_controller).
//  Accepts one load/store request at a time via valid/ready, applies RV32I byte/half/word lane rules.
//  Returns read data or a trap after a fixed, parameterised latency through a held response handshake.
//  Sits between the core's RAM controller and on-chip word-wide storage.
// PARAMETERS
//  MEM_WORDS  1024  number of 32-bit words stored; power of 2
//  LATENCY    2     cycles from request-accept edge to rsp_valid high; legal range >= 1
// PORTS
//  clk        in   1   clock, all logic on posedge
//  rst        in   1   synchronous reset, active-high
//  req_valid  in   1   request present
//  req_ready  out  1   responder can accept (high only in IDLE)
//  req_write  in   1   1 = store, 0 = load
//  req_addr   in   32  byte address
//  req_func3  in   3   RV32I width/sign code from the instruction
//  req_wdata  in   32  store data; low bits used for SB/SH
//  rsp_valid  out  1   response present; held until rsp_ready
//  rsp_ready  in   1   initiator accepts response
//  rsp_rdata  out  32  load result (extended); 0 for stores and traps
//  rsp_trap   out  1   request faulted (misaligned / out of range / bad func3)
// BEHAVIOUR
//  Reset: state=IDLE, lat_cnt=0, rsp_valid=0, rsp_rdata=0, rsp_trap=0; memory contents not reset.
//  req_ready=0 while rst is high; req_ready=1 in IDLE after reset; 0 in WAIT/RESP. No pipelining.
//  FSM IDLE -> (req_valid&&req_ready) latch addr/func3/wdata/write, compute trap.
//    Then go to WAIT with lat_cnt=LATENCY-1, or straight to RESP if LATENCY==1.
//  WAIT: lat_cnt decrements each cycle; at lat_cnt==1 next state is RESP.
//    Result: rsp_valid rises exactly LATENCY cycles after the accept edge.
//  Entry edge into RESP: store byte-lanes written and load data captured, on the same edge.
//    A request accepted after this edge observes the store.
//  RESP: rsp_valid=1; rsp_rdata and rsp_trap held stable until rsp_valid&&rsp_ready, then IDLE.
//    rsp_valid falls in the cycle after the handshake.
//  req_valid outside IDLE is ignored; no request is queued.
//  Trap conditions (any one -> rsp_trap=1, rsp_rdata=0, no memory write):
//    func3 not in {000,001,010,100,101} for loads, or not in {000,001,010} for stores
//    half (001/101) with addr[0]!=0; word (010) with addr[1:0]!=0
//    addr[31:2] >= MEM_WORDS (no wrap-around; upper address bits are checked)
//  Word index = addr[$clog2(MEM_WORDS)+1:2]. Little-endian lanes: byte k = bits [8k+7:8k].
//  Loads: LB sign-extends byte addr[1:0]; LBU zero-extends it.
//    LH/LHU read half addr[1] (bits [15:0] or [31:16]) with sign/zero extension; LW returns the word.
//  Stores: SB writes lane addr[1:0] with wdata[7:0]; SH writes lanes {2*addr[1],+1} with wdata[15:0].
//    SW writes all 4 lanes. Other lanes are unchanged.
//  Stores return rsp_rdata=0, rsp_trap=0 when legal.
//  rst in WAIT/RESP: request dropped, uncommitted store not written, all outputs take reset values.
// STRUCTURE
//  Package mem_resp_pkg holds:
//    func3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101
//    typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_resp_state_t
//  Sub-module mem_lane_align (combinational) takes func3, addr[1:0], wdata, rword.
//    Outputs: byte_en[3:0], aligned wdata, extended rdata, misalign flag.
//  Top level holds the FSM, latency counter, storage array, range check and response registers.
// TESTING (MEM_WORDS=1024, LATENCY=2 unless stated)
//  1. SW 0xDEADBEEF @0x10, then LW @0x10 -> rdata=0xDEADBEEF, trap=0.
//     rsp_valid exactly 2 cycles after each accept; repeat with LATENCY=1 -> 1 cycle.
//  2. SB wdata=0x80 @0x13; LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80ADBEEF.
//  3. LH @0x11 -> trap=1, rdata=0; SW 0x1 @0x12 -> trap=1; LW @0x10 still 0x80ADBEEF.
//  4. LW @0x1000 -> trap (out of range); load func3=011 -> trap; store func3=100 -> trap.
//  5. Hold rsp_ready=0 for 5 cycles in RESP: rsp_valid/rdata/trap stable, req_ready=0.
//     A req_valid pulse during this time produces no second response.
//  6. SW 0x12345678 @0x20, assert rst in WAIT: outputs reset next cycle.
//     Subsequent LW @0x20 returns the prior value (no write).

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_resp_pkg;

    // RV32I load/store width codes (funct3 field)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_resp_state_t;

    // Stores only have signed-width codes; loads also allow the unsigned variants.
    function automatic logic f3Legal(input logic isWrite, input logic [2:0] f3);
        logic common;
        common = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (isWrite) return common;
        return common || (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for RV32I loads and stores on a little-endian 32-bit word.
module mem_lane_align
    import mem_resp_pkg::*;
(
    input  logic [2:0]  i_func3,
    input  logic [1:0]  i_addrLo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_byteEn,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic [0:0]  o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte out of the stored word
    always_comb begin
        w_byte = i_rword[7:0];
        case (i_addrLo)
            2'd0:    w_byte = i_rword[7:0];
            2'd1:    w_byte = i_rword[15:8];
            2'd2:    w_byte = i_rword[23:16];
            default: w_byte = i_rword[31:24];
        endcase
    end

    assign w_half = i_addrLo[1] ? i_rword[31:16] : i_rword[15:0];

    // Lane enables, replicated store data, extended load data and alignment fault
    always_comb begin
        o_byteEn   = 4'b0000;
        o_wdata    = i_wdata;
        o_rdata    = 32'h0;
        o_misalign = 1'b0;
        case (i_func3)
            F3_B: begin
                o_byteEn = 4'b0001 << i_addrLo;
                o_wdata  = {4{i_wdata[7:0]}};
                o_rdata  = {{24{w_byte[7]}}, w_byte};
            end
            F3_BU: begin
                o_byteEn = 4'b0001 << i_addrLo;
                o_wdata  = {4{i_wdata[7:0]}};
                o_rdata  = {24'h0, w_byte};
            end
            F3_H: begin
                o_byteEn   = i_addrLo[1] ? 4'b1100 : 4'b0011;
                o_wdata    = {2{i_wdata[15:0]}};
                o_rdata    = {{16{w_half[15]}}, w_half};
                o_misalign = i_addrLo[0];
            end
            F3_HU: begin
                o_byteEn   = i_addrLo[1] ? 4'b1100 : 4'b0011;
                o_wdata    = {2{i_wdata[15:0]}};
                o_rdata    = {16'h0, w_half};
                o_misalign = i_addrLo[0];
            end
            F3_W: begin
                o_byteEn   = 4'b1111;
                o_rdata    = i_rword;
                o_misalign = |i_addrLo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Target end of the CPU data-memory interface: one request at a time, fixed
// response latency, held response until the initiator takes it.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_trap
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    mem_resp_state_t r_state;
    mem_resp_state_t w_nextState;
    logic [CNT_W-1:0] r_latCnt;

    logic        r_write;
    logic [31:0] r_addr;
    logic [2:0]  r_func3;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_trap;
    logic [31:0] r_mem [MEM_WORDS];

    logic             w_accept;
    logic             w_commit;
    logic             w_curWrite;
    logic [31:0]      w_curAddr;
    logic [2:0]       w_curFunc3;
    logic [31:0]      w_curWdata;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_rword;
    logic             w_inRange;
    logic             w_trap;
    logic [3:0]       w_byteEn;
    logic [31:0]      w_alignWdata;
    logic [31:0]      w_alignRdata;
    logic [0:0]       w_misalign;

    assign w_accept = req_valid && req_ready;

    // With LATENCY==1 the accept edge is also the commit edge, so the live
    // request has to feed the datapath while idle; afterwards the latched copy does.
    assign w_curWrite = (r_state == IDLE) ? req_write : r_write;
    assign w_curAddr  = (r_state == IDLE) ? req_addr  : r_addr;
    assign w_curFunc3 = (r_state == IDLE) ? req_func3 : r_func3;
    assign w_curWdata = (r_state == IDLE) ? req_wdata : r_wdata;

    assign w_idx     = w_curAddr[IDX_W+1:2];
    assign w_rword   = r_mem[w_idx];
    assign w_inRange = (w_curAddr[31:2] < 30'(MEM_WORDS));
    assign w_trap    = !f3Legal(w_curWrite, w_curFunc3) || w_misalign[0] || !w_inRange;

    assign w_commit = ((r_state == IDLE) && w_accept && (LATENCY == 1)) ||
                      ((r_state == WAIT) && (r_latCnt == CNT_W'(1)));

    mem_lane_align u_align (
        .i_func3    (w_curFunc3),
        .i_addrLo   (w_curAddr[1:0]),
        .i_wdata    (w_curWdata),
        .i_rword    (w_rword),
        .o_byteEn   (w_byteEn),
        .o_wdata    (w_alignWdata),
        .o_rdata    (w_alignRdata),
        .o_misalign (w_misalign)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    // Next-state: accept -> wait out the latency -> hold response until taken
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_nextState = (LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (r_latCnt == CNT_W'(1)) w_nextState = RESP;
            RESP:    if (rsp_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Handshake outputs; ready is suppressed while reset is asserted
    always_comb begin
        req_ready = (r_state == IDLE) && !rst;
        rsp_valid = (r_state == RESP);
    end

    // Request latch, latency counter and response capture on the commit edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_latCnt <= '0;
            r_write  <= 1'b0;
            r_addr   <= 32'h0;
            r_func3  <= 3'b000;
            r_wdata  <= 32'h0;
            r_rdata  <= 32'h0;
            r_trap   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write  <= req_write;
                r_addr   <= req_addr;
                r_func3  <= req_func3;
                r_wdata  <= req_wdata;
                r_latCnt <= CNT_W'(LATENCY - 1);
            end else if (r_state == WAIT) begin
                r_latCnt <= r_latCnt - CNT_W'(1);
            end
            if (w_commit) begin
                r_trap  <= w_trap;
                r_rdata <= (w_trap || w_curWrite) ? 32'h0 : w_alignRdata;
            end
        end
    end

    // Storage write: only legal stores that reach the commit edge outside reset
    always_ff @(posedge clk) begin
        if (!rst && w_commit && w_curWrite && !w_trap) begin
            for (int k = 0; k < 4; k++) begin
                if (w_byteEn[k]) r_mem[w_idx][8*k +: 8] <= w_alignWdata[8*k +: 8];
            end
        end
    end

    assign rsp_rdata = r_rdata;
    assign rsp_trap  = r_trap;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: table of request vectors with a response scoreboard,
// plus hand-written back-pressure, reset-abort and LATENCY=1 sequences.
module tb_mem_responder;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic        expTrap;
    } vec_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        trap;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        reqValid;
    logic        reqWrite;
    logic [31:0] reqAddr;
    logic [2:0]  reqFunc3;
    logic [31:0] reqWdata;
    logic        rspReady;
    logic        useFast;

    logic        reqReady0, rspValid0, rspTrap0;
    logic [31:0] rspRdata0;
    logic        reqReady1, rspValid1, rspTrap1;
    logic [31:0] rspRdata1;
    logic        reqValid0, reqValid1;
    logic        reqReadyM, rspValidM, rspTrapM;
    logic [31:0] rspRdataM;

    int   nTests = 0;
    int   nFail  = 0;
    exp_t expQ[$];
    vec_t vecs[21];

    assign reqValid0 = reqValid && !useFast;
    assign reqValid1 = reqValid && useFast;
    assign reqReadyM = useFast ? reqReady1 : reqReady0;
    assign rspValidM = useFast ? rspValid1 : rspValid0;
    assign rspRdataM = useFast ? rspRdata1 : rspRdata0;
    assign rspTrapM  = useFast ? rspTrap1  : rspTrap0;

    mem_responder #(.MEM_WORDS(1024), .LATENCY(2)) u_dutSlow (
        .clk(clk), .rst(rst),
        .req_valid(reqValid0), .req_ready(reqReady0), .req_write(reqWrite),
        .req_addr(reqAddr), .req_func3(reqFunc3), .req_wdata(reqWdata),
        .rsp_valid(rspValid0), .rsp_ready(rspReady),
        .rsp_rdata(rspRdata0), .rsp_trap(rspTrap0)
    );

    mem_responder #(.MEM_WORDS(1024), .LATENCY(1)) u_dutFast (
        .clk(clk), .rst(rst),
        .req_valid(reqValid1), .req_ready(reqReady1), .req_write(reqWrite),
        .req_addr(reqAddr), .req_func3(reqFunc3), .req_wdata(reqWdata),
        .rsp_valid(rspValid1), .rsp_ready(rspReady),
        .rsp_rdata(rspRdata1), .rsp_trap(rspTrap1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic driveReq(input vec_t v);
        reqValid = 1'b1;
        reqWrite = v.write;
        reqAddr  = v.addr;
        reqFunc3 = v.f3;
        reqWdata = v.wdata;
    endtask

    // Waits at negedges for rsp_valid; returns cycles since the accept edge, 0 on timeout
    task automatic waitRsp(input string tag, output int cnt);
        cnt = 1;
        while (!rspValidM && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        if (!rspValidM) begin
            nTests++;
            nFail++;
            $display("[TB] FAIL %s timeout: rsp_valid 0, required 1", tag);
            cnt = 0;
        end
    endtask

    // One full request/response with rsp_ready held high; entered and left at a negedge
    task automatic applyStimulus(input vec_t v, input int expLat, input string tag);
        int   cnt;
        exp_t e;
        checkOutput({tag, " req_ready"}, {31'h0, reqReadyM}, 32'd1);
        rspReady = 1'b1;
        driveReq(v);
        e.rdata = v.expRdata;
        e.trap  = v.expTrap;
        expQ.push_back(e);
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        waitRsp(tag, cnt);
        e = expQ.pop_front();
        if (cnt != 0) begin
            checkOutput({tag, " latency"}, cnt, expLat);
            checkOutput({tag, " rdata"}, rspRdataM, e.rdata);
            checkOutput({tag, " trap"}, {31'h0, rspTrapM}, {31'h0, e.trap});
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, " rsp_valid drop"}, {31'h0, rspValidM}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int   cnt;
        exp_t e;
        vec_t v;

        vecs[0]  = '{1'b1, 32'h0000_0010, 3'b010, 32'hDEADBEEF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 3'b010, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0013, 3'b000, 32'h0000_0080, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0013, 3'b000, 32'h0,        32'hFFFFFF80, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0013, 3'b100, 32'h0,        32'h0000_0080, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0010, 3'b010, 32'h0,        32'h80ADBEEF, 1'b0};
        vecs[6]  = '{1'b0, 32'h0000_0011, 3'b001, 32'h0,        32'h0000_0000, 1'b1};
        vecs[7]  = '{1'b1, 32'h0000_0012, 3'b010, 32'h0000_0001, 32'h0000_0000, 1'b1};
        vecs[8]  = '{1'b0, 32'h0000_0010, 3'b010, 32'h0,        32'h80ADBEEF, 1'b0};
        vecs[9]  = '{1'b0, 32'h0000_1000, 3'b010, 32'h0,        32'h0000_0000, 1'b1};
        vecs[10] = '{1'b0, 32'h0000_0010, 3'b011, 32'h0,        32'h0000_0000, 1'b1};
        vecs[11] = '{1'b1, 32'h0000_0010, 3'b100, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[12] = '{1'b0, 32'h0000_0010, 3'b010, 32'h0,        32'h80ADBEEF, 1'b0};
        vecs[13] = '{1'b1, 32'h0000_0012, 3'b001, 32'hA5A51234, 32'h0000_0000, 1'b0};
        vecs[14] = '{1'b0, 32'h0000_0012, 3'b101, 32'h0,        32'h0000_1234, 1'b0};
        vecs[15] = '{1'b0, 32'h0000_0010, 3'b001, 32'h0,        32'hFFFFBEEF, 1'b0};
        vecs[16] = '{1'b0, 32'h0000_0010, 3'b010, 32'h0,        32'h1234BEEF, 1'b0};
        vecs[17] = '{1'b1, 32'h0000_0020, 3'b010, 32'hCAFEF00D, 32'h0000_0000, 1'b0};
        vecs[18] = '{1'b1, 32'h0000_0FFC, 3'b010, 32'h0BADF00D, 32'h0000_0000, 1'b0};
        vecs[19] = '{1'b0, 32'h0000_0FFC, 3'b010, 32'h0,        32'h0BADF00D, 1'b0};
        vecs[20] = '{1'b0, 32'h8000_0010, 3'b010, 32'h0,        32'h0000_0000, 1'b1};

        rst      = 1'b1;
        reqValid = 1'b0;
        reqWrite = 1'b0;
        reqAddr  = 32'h0;
        reqFunc3 = 3'b000;
        reqWdata = 32'h0;
        rspReady = 1'b1;
        useFast  = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("req_ready in reset", {31'h0, reqReadyM}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset req_ready", {31'h0, reqReadyM}, 32'd1);
        checkOutput("reset rsp_valid", {31'h0, rspValidM}, 32'd0);
        checkOutput("reset rdata", rspRdataM, 32'h0);
        checkOutput("reset trap", {31'h0, rspTrapM}, 32'd0);

        for (int i = 0; i < 21; i++) applyStimulus(vecs[i], 2, $sformatf("vec%0d", i));

        useFast = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) applyStimulus(vecs[i], 1, $sformatf("fast%0d", i));
        useFast = 1'b0;
        @(negedge clk);

        // Back-pressure: response held for 5 cycles, stray request ignored
        v = '{1'b0, 32'h0000_0010, 3'b010, 32'h0, 32'h1234BEEF, 1'b0};
        rspReady = 1'b0;
        driveReq(v);
        e.rdata = v.expRdata;
        e.trap  = v.expTrap;
        expQ.push_back(e);
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        waitRsp("hold", cnt);
        e = expQ.pop_front();
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("hold%0d rsp_valid", i), {31'h0, rspValidM}, 32'd1);
            checkOutput($sformatf("hold%0d rdata", i), rspRdataM, e.rdata);
            checkOutput($sformatf("hold%0d trap", i), {31'h0, rspTrapM}, {31'h0, e.trap});
            checkOutput($sformatf("hold%0d req_ready", i), {31'h0, reqReadyM}, 32'd0);
            if (i == 1) driveReq('{1'b1, 32'h0000_0010, 3'b010, 32'hFFFF_FFFF, 32'h0, 1'b0});
            @(negedge clk);
            reqValid = 1'b0;
        end
        rspReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("no second rsp %0d", i), {31'h0, rspValidM}, 32'd0);
            @(negedge clk);
        end
        applyStimulus('{1'b0, 32'h0000_0010, 3'b010, 32'h0, 32'h1234BEEF, 1'b0}, 2, "after hold");

        // Reset while waiting: store must not land, outputs return to reset values
        driveReq('{1'b1, 32'h0000_0020, 3'b010, 32'h12345678, 32'h0, 1'b0});
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort rsp_valid", {31'h0, rspValidM}, 32'd0);
        checkOutput("abort rdata", rspRdataM, 32'h0);
        checkOutput("abort trap", {31'h0, rspTrapM}, 32'd0);
        checkOutput("abort req_ready", {31'h0, reqReadyM}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus('{1'b0, 32'h0000_0020, 3'b010, 32'h0, 32'hCAFEF00D, 1'b0}, 2, "after abort");

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
